// File: rtl/score_display_pkg.sv
// score_display_pkg
//   Shared definitions for the score display controller: FSM state encoding,
//   binary/BCD widths, the saturation limit and the double-dabble nibble
//   adjustment used by the converter.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam int MAX_VALUE = 9999;
    localparam int BIN_W     = 14;
    localparam int DIGITS    = 4;
    localparam int BCD_W     = 16;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// seven_segment
//   Decimal digit to active-low 7-segment decoder, segment order {a..g}.
//   Ports:
//     digit : BCD digit 0..9 (codes above 9 show blank)
//     en    : 0 forces the digit blank (all segments off)
//     seg   : active-low segment outputs {a,b,c,d,e,f,g}
module seven_segment (
    input  logic [3:0] digit,
    input  logic       en,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        if (en) begin
            case (digit)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0000100;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts a 14-bit binary score to four BCD digits (serial double-dabble,
//   one shift per cycle) and drives four 7-segment displays with optional
//   leading-zero blanking and whole-display blinking.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     load, value   : start a conversion of value (saturated to 9999); only
//                     accepted while idle
//     blank_lz      : blank leading zero digits (combinational)
//     blink         : flash the display at BLINK_DIV cycles per half-period
//     busy          : conversion in progress
//     done          : one-cycle pulse when new digits are shown
//     hex0..hex3    : active-low segments {a..g}, hex0 = ones digit
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    input  logic              blank_lz,
    input  logic              blink,
    output logic              busy,
    output logic              done,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3
);

    localparam int                BLK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BIN_W-1:0]  MAX_BIN = BIN_W'(MAX_VALUE);
    localparam logic [BLK_W-1:0]  BLK_TOP = BLK_W'(BLINK_DIV - 1);

    state_t                   state, state_nxt;
    logic [BCD_W-1:0]         bcd_q;
    logic [BIN_W-1:0]         bin_q;
    logic [3:0]               cnt_q;
    logic [BCD_W-1:0]         digits_q;
    logic                     done_q;
    logic [BLK_W-1:0]         blk_cnt;
    logic                     phase;
    logic [BCD_W+BIN_W-1:0]   shift_src;
    logic [DIGITS-1:0]        nz;
    logic [DIGITS-1:0]        en;
    logic [6:0]               seg [DIGITS];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == 4'd1) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign shift_src = {bcd_adjust(bcd_q), bin_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        bin_q <= (value > MAX_BIN) ? MAX_BIN : value;
                        bcd_q <= '0;
                        cnt_q <= 4'(BIN_W);
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {shift_src[BCD_W+BIN_W-2:0], 1'b0};
                    cnt_q          <= cnt_q - 4'd1;
                end
                ST_UPDATE: begin
                    digits_q <= bcd_q;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink divider; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (blk_cnt == BLK_TOP) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // A digit is shown if it or any more significant digit is nonzero;
    // the ones digit always shows so zero displays as "0".
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            nz[k] = (digits_q[k*4 +: 4] != 4'd0);
        end
        en[3] = nz[3];
        en[2] = nz[3] | nz[2];
        en[1] = nz[3] | nz[2] | nz[1];
        en[0] = 1'b1;
        if (!blank_lz) en = '1;
        if (blink && phase) en = '0;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seven_segment u_seg (
            .digit (digits_q[g*4 +: 4]),
            .en    (en[g]),
            .seg   (seg[g])
        );
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign busy = (state != ST_IDLE);
    assign done = done_q;

endmodule
